ps2_scan_receiver: RTL and testbench

Parametrised PS/2 keyboard receiver that succeeds the fixed single-byte capture path. It synchronises and glitch-filters the raw PS/2 lines in the system clock domain and frames 11-bit packets with start, parity and stop checks plus an inter-bit timeout. It optionally merges E0/F0 prefixes into key events and buffers events in a show-ahead FIFO with a valid/ready handshake. It sits between the PS/2 pins and any consumer, such as the hex display decoder or game logic.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_sync_filter.sv | 44 ++++
 rtl/ps2_scan_receiver.sv | 223 ++++++++++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scan-code receiver.
// Holds the event bundle, the frame FSM states and the prefix byte values.
package ps2_pkg;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ps2_event_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: 2-FF synchroniser plus stable-level filter for a pin.
// Ports: clk, reset_n, din (async pin) -> level (filtered), fall (1-cycle).
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // level only moves after FILTER_LEN consecutive
  // samples disagree with it; fall marks a 1->0 move
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      fall <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= s2;
        cnt   <= '0;
        fall  <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 frame receiver, optional E0/F0 merge
// (PS2_PREFIX_EN), show-ahead event FIFO with valid/ready.
// Ports: clk, reset_n, ps2_clk, ps2_data in; ev_valid/ev_ready,
// ev_code, ev_break, ev_ext, frame_err, overflow.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_break,
  output logic       ev_ext,
  output logic       frame_err,
  output logic       overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic       clk_lvl;
  logic       fall;
  logic       d1;
  logic       d2;

  ps2_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filt (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (ps2_clk),
    .level  (clk_lvl),
    .fall   (fall)
  );

  // data is sampled well after the clock edge, so
  // a plain synchroniser is enough here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1 <= 1'b1;
      d2 <= 1'b1;
    end else begin
      d1 <= ps2_data;
      d2 <= d1;
    end
  end

  ps2_state_e    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] to_cnt;

  logic timeout;
  logic stop_smp;
  logic good;
  logic frame_ok;
  logic frame_bad;

  assign timeout   = (state != IDLE) && !fall &&
                     (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign stop_smp  = fall && (state == STOP);
  assign good      = d2 && (^{shreg, par});
  assign frame_ok  = stop_smp && good;
  assign frame_bad = stop_smp && !good;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (timeout) begin
        state     <= IDLE;
        to_cnt    <= '0;
        frame_err <= 1'b1;
      end else if (fall) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (d2) begin
              frame_err <= 1'b1;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {d2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= d2;
            state <= STOP;
          end
          STOP: begin
            state     <= IDLE;
            frame_err <= !good;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  logic       push_vld;
  ps2_event_t push_ev;

`ifdef PS2_PREFIX_EN
  logic ext_f;
  logic brk_f;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_f    <= 1'b0;
      brk_f    <= 1'b0;
      push_vld <= 1'b0;
      push_ev  <= '0;
    end else begin
      push_vld <= 1'b0;
      if (timeout || frame_bad) begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end else if (frame_ok) begin
        if (shreg == PS2_PREFIX_EXT) begin
          ext_f <= 1'b1;
        end else if (shreg == PS2_PREFIX_BRK) begin
          brk_f <= 1'b1;
        end else begin
          push_vld     <= 1'b1;
          push_ev.code <= shreg;
          push_ev.brk  <= brk_f;
          push_ev.ext  <= ext_f;
          ext_f        <= 1'b0;
          brk_f        <= 1'b0;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      push_vld <= 1'b0;
      push_ev  <= '0;
    end else begin
      push_vld <= frame_ok;
      if (frame_ok) begin
        push_ev.code <= shreg;
        push_ev.brk  <= 1'b0;
        push_ev.ext  <= 1'b0;
      end
    end
  end
`endif

  ps2_event_t    mem [FIFO_DEPTH];
  ps2_event_t    head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop;
  logic          full;
  logic          wr_en;

  assign ev_valid = (count != '0);
  assign pop      = ev_valid && ev_ready;
  assign full     = (count == CW'(FIFO_DEPTH));
  // a pop frees the slot this cycle, so a full
  // FIFO may still take the push
  assign wr_en    = push_vld && (!full || pop);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_ev;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_vld && full && !pop;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // stale RAM contents stay hidden while empty
  assign ev_code = ev_valid ? head.code : 8'h00;

`ifdef PS2_PREFIX_EN
  assign ev_break = ev_valid & head.brk;
  assign ev_ext   = ev_valid & head.ext;
`else
  logic unused_flags;
  assign unused_flags = head.brk ^ head.ext;
  assign ev_break     = 1'b0;
  assign ev_ext       = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: scoreboard bench for ps2_scan_receiver.
// Drives PS/2 frames, queues expected events, checks pops and pulses.
module tb_ps2_scan_receiver;
  import ps2_pkg::*;

  localparam int FL    = 4;
  localparam int TO    = 2000;
  localparam int DEPTH = 8;
  localparam int HALF  = 20;

  logic       clk;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;
  logic       frame_err;
  logic       overflow;

  ps2_scan_receiver #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_code  (ev_code),
    .ev_break (ev_break),
    .ev_ext   (ev_ext),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ps2_event_t q[$];
  int vecs = 0;
  int errs = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic ps2_event_t mk(input logic [7:0] c,
                                    input logic b,
                                    input logic e);
    ps2_event_t r;
    r.code = c;
    r.brk  = b;
    r.ext  = e;
    return r;
  endfunction

  ps2_event_t exp_ev;
  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_err) ferr_cnt++;
      if (overflow) ovf_cnt++;
      if (ev_valid && ev_ready) begin
        if (q.size() == 0) begin
          chk("spurious_ev", q.size(), 1);
        end else begin
          exp_ev = q.pop_front();
          chk("ev", {22'b0, ev_code, ev_break, ev_ext},
              {22'b0, exp_ev});
        end
      end
    end
  end

  task automatic send(input logic [7:0] b,
                      input bit badp,
                      input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ badp, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 600; i++) begin
      if (q.size() == 0 && !ev_valid) break;
      @(negedge clk);
    end
    chk({tag, "_left"}, q.size(), 0);
    chk({tag, "_valid"}, ev_valid, 0);
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, "_valid"}, ev_valid, 0);
    chk({tag, "_code"}, ev_code, 0);
    chk({tag, "_brk"}, ev_break, 0);
    chk({tag, "_ext"}, ev_ext, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  int e0;

  initial begin
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    ev_ready = 1'b1;
    reset_n  = 1'b0;
    repeat (5) @(negedge clk);
    zero_outs("rst");
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    q.push_back(mk(8'h1C, 1'b0, 1'b0));
    send(8'h1C, 1'b0, 11);
    drain("a_key");
    chk("a_key_ferr", ferr_cnt, 0);

`ifdef PS2_PREFIX_EN
    q.push_back(mk(8'h75, 1'b1, 1'b1));
`else
    q.push_back(mk(8'hE0, 1'b0, 1'b0));
    q.push_back(mk(8'hF0, 1'b0, 1'b0));
    q.push_back(mk(8'h75, 1'b0, 1'b0));
`endif
    send(8'hE0, 1'b0, 11);
    send(8'hF0, 1'b0, 11);
    send(8'h75, 1'b0, 11);
    drain("prefix");
    chk("prefix_ferr", ferr_cnt, 0);

    e0 = ferr_cnt;
    send(8'h1C, 1'b1, 11);
    repeat (20) @(negedge clk);
    chk("par_ferr", ferr_cnt, e0 + 1);
    chk("par_noev", ev_valid, 0);
    q.push_back(mk(8'h32, 1'b0, 1'b0));
    send(8'h32, 1'b0, 11);
    drain("after_par");
    chk("after_par_ferr", ferr_cnt, e0 + 1);

    e0 = ferr_cnt;
    send(8'h15, 1'b0, 6);
    repeat (TO + 200) @(negedge clk);
    chk("to_ferr", ferr_cnt, e0 + 1);
    chk("to_noev", ev_valid, 0);
    q.push_back(mk(8'h24, 1'b0, 1'b0));
    send(8'h24, 1'b0, 11);
    drain("after_to");
    chk("after_to_ferr", ferr_cnt, e0 + 1);

    ev_ready = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      if (i <= DEPTH) q.push_back(mk(8'(i), 1'b0, 1'b0));
      send(8'(i), 1'b0, 11);
    end
    repeat (20) @(negedge clk);
    chk("ovf_cnt", ovf_cnt, 1);
    chk("ovf_valid", ev_valid, 1);
    chk("ovf_head", ev_code, 8'h01);
    ev_ready = 1'b1;
    drain("ovf");

    e0 = ferr_cnt;
    ev_ready = 1'b0;
    send(8'h11, 1'b0, 11);
    chk("pre_rst_valid", ev_valid, 1);
    send(8'h5A, 1'b0, 5);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    zero_outs("mid_rst");
    reset_n = 1'b1;
    ev_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_valid", ev_valid, 0);
    q.push_back(mk(8'h29, 1'b0, 1'b0));
    send(8'h29, 1'b0, 11);
    drain("post_rst");
    chk("post_rst_ferr", ferr_cnt, e0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
